// File: rtl/bsg_clk_mon_pkg.sv
// Shared definitions for the clock-monitor frequency meter: FSM state encoding and default widths.
package bsg_clk_mon_pkg;

    localparam int unsigned meter_window_width_gp = 16;
    localparam int unsigned meter_count_width_gp  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StCount = 2'd2,
        StDone  = 2'd3
    } bsg_clk_mon_meter_state_e;

endpackage

// File: rtl/bsg_sync_edge_det.sv
// Two-flop synchronizer followed by an edge register; flags rising edges of an asynchronous input.
module bsg_sync_edge_det (
    input  logic clk,
    input  logic async_reset_n,
    input  logic data,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic sync_d_q;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            sync_d_q <= 1'b0;
        end else begin
            meta_q   <= data;
            sync_q   <= meta_q;
            sync_d_q <= sync_q;
        end
    end

    assign rise = sync_q & ~sync_d_q;

endmodule

// File: rtl/bsg_clk_mon_meter.sv
// Windowed frequency meter: counts synchronized div_clk_i rising edges over window_i reference cycles.
// Optional lock detector compiled in with `define BSG_CLK_MON_METER_LOCK_EN.
module bsg_clk_mon_meter
    import bsg_clk_mon_pkg::*;
#(
    parameter int unsigned window_width_p = meter_window_width_gp,
    parameter int unsigned count_width_p  = meter_count_width_gp
`ifdef BSG_CLK_MON_METER_LOCK_EN
   ,parameter int unsigned lock_cnt_p     = 4
`endif
) (
    input  logic                      clk_i,
    input  logic                      async_reset_n_i,
    input  logic                      div_clk_i,
    input  logic                      en_i,
    input  logic [window_width_p-1:0] window_i,
    output logic [count_width_p-1:0]  meas_o,
    output logic                      meas_v_o,
    input  logic                      meas_yumi_i,
    output logic                      overrun_o
`ifdef BSG_CLK_MON_METER_LOCK_EN
   ,input  logic [count_width_p-1:0]  target_i
   ,input  logic [count_width_p-1:0]  tol_i
   ,output logic                      lock_o
`endif
);

    bsg_clk_mon_meter_state_e state_q, state_d;
    logic [window_width_p-1:0] cyc_q, cyc_d;
    logic [count_width_p-1:0]  cnt_q, cnt_d;
    logic [count_width_p-1:0]  meas_q, meas_d;
    logic                      meas_v_q, meas_v_d;
    logic                      overrun_q, overrun_d;
    logic                      rise;

    bsg_sync_edge_det u_sync (
        .clk           (clk_i),
        .async_reset_n (async_reset_n_i),
        .data          (div_clk_i),
        .rise          (rise)
    );

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        cnt_d     = cnt_q;
        meas_d    = meas_q;
        meas_v_d  = meas_v_q & ~meas_yumi_i;
        overrun_d = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (en_i) state_d = StArm;
            end
            StArm: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else begin
                    // A zero window behaves as one, so the down-counter starts at 0 either way.
                    cyc_d   = (window_i == '0) ? '0 : window_i - 1'b1;
                    cnt_d   = '0;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else begin
                    if (rise && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                    if (cyc_q == '0) state_d = StDone;
                    else             cyc_d   = cyc_q - 1'b1;
                end
            end
            StDone: begin
                meas_d   = cnt_q;
                meas_v_d = 1'b1;
                if (meas_v_q && !meas_yumi_i) overrun_d = 1'b1;
                state_d  = en_i ? StArm : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            cnt_q     <= '0;
            meas_q    <= '0;
            meas_v_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            meas_q    <= meas_d;
            meas_v_q  <= meas_v_d;
            overrun_q <= overrun_d;
        end
    end

    assign meas_o    = meas_q;
    assign meas_v_o  = meas_v_q;
    assign overrun_o = overrun_q;

`ifdef BSG_CLK_MON_METER_LOCK_EN
    localparam int unsigned lock_width_lp = $clog2(lock_cnt_p + 1);
    localparam logic [lock_width_lp-1:0] lock_max_lp = lock_width_lp'(lock_cnt_p);

    logic [lock_width_lp-1:0] lock_cnt_q, lock_cnt_d;
    logic                     lock_q, lock_d;
    logic [count_width_p:0]   dev;
    logic                     in_range;

    always_comb begin
        dev = (cnt_q >= target_i) ? {1'b0, cnt_q} - {1'b0, target_i}
                                  : {1'b0, target_i} - {1'b0, cnt_q};
        in_range   = (dev <= {1'b0, tol_i});
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (state_q == StDone) begin
            if (in_range) begin
                if (lock_cnt_q != lock_max_lp) lock_cnt_d = lock_cnt_q + 1'b1;
                lock_d = (lock_cnt_d == lock_max_lp);
            end else begin
                lock_cnt_d = '0;
                lock_d     = 1'b0;
            end
        end
        if (state_d == StIdle) begin
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign lock_o = lock_q;
`endif

endmodule

// File: tb/tb_bsg_clk_mon_meter.sv
// Randomized bench for bsg_clk_mon_meter against a window-position reference model.
module tb_bsg_clk_mon_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_clk = 1'b0;
    logic        en = 1'b0;
    logic        yumi = 1'b0;
    logic [15:0] window = 16'd0;
    logic [15:0] meas;
    logic        meas_v, overrun;
    logic [3:0]  meas_s;
    logic        meas_v_s, overrun_s;
`ifdef BSG_CLK_MON_METER_LOCK_EN
    logic [15:0] target = 16'd10;
    logic [15:0] tol = 16'd1;
    logic        lock, lock_s;
    logic [3:0]  target_s = 4'd10;
    logic [3:0]  tol_s = 4'd1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_clk_mon_meter u_dut (
        .clk_i           (clk),
        .async_reset_n_i (rst_n),
        .div_clk_i       (div_clk),
        .en_i            (en),
        .window_i        (window),
        .meas_o          (meas),
        .meas_v_o        (meas_v),
        .meas_yumi_i     (yumi),
        .overrun_o       (overrun)
`ifdef BSG_CLK_MON_METER_LOCK_EN
       ,.target_i        (target)
       ,.tol_i           (tol)
       ,.lock_o          (lock)
`endif
    );

    bsg_clk_mon_meter #(.count_width_p(4)) u_sat (
        .clk_i           (clk),
        .async_reset_n_i (rst_n),
        .div_clk_i       (div_clk),
        .en_i            (en),
        .window_i        (window),
        .meas_o          (meas_s),
        .meas_v_o        (meas_v_s),
        .meas_yumi_i     (yumi),
        .overrun_o       (overrun_s)
`ifdef BSG_CLK_MON_METER_LOCK_EN
       ,.target_i        (target_s)
       ,.tol_i           (tol_s)
       ,.lock_o          (lock_s)
`endif
    );

    // Reference model: pos -1 idle, 0 arm, 1..win counting, win+1 result cycle.
    int   m_pos = -1;
    int   m_win = 1;
    int   m_cnt = 0;
    int   m_cnt_s = 0;
    int   m_meas = 0;
    int   m_meas_s = 0;
    logic m_v = 1'b0;
    logic m_ovr = 1'b0;
    int   m_lcnt = 0;
    logic m_lock = 1'b0;
    logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;

    always @(posedge clk) begin
        int   pos, win, cnt, cnts, mm, mms, lcnt, dev;
        logic v, ovr, lck, edge_seen;
        if (!rst_n) begin
            m_pos <= -1; m_win <= 1; m_cnt <= 0; m_cnt_s <= 0; m_meas <= 0; m_meas_s <= 0;
            m_v <= 1'b0; m_ovr <= 1'b0; m_lcnt <= 0; m_lock <= 1'b0;
            p1 <= 1'b0; p2 <= 1'b0; p3 <= 1'b0;
        end else begin
            // Edge visible to the counter now is the div_clk transition sampled 2-3 edges ago.
            edge_seen = p2 & ~p3;
            pos = m_pos; win = m_win; cnt = m_cnt; cnts = m_cnt_s;
            mm = m_meas; mms = m_meas_s; v = m_v; ovr = m_ovr; lcnt = m_lcnt; lck = m_lock;
            if (yumi) v = 1'b0;
            if (pos < 0) begin
                if (en) pos = 0;
            end else if (pos == 0) begin
                if (!en) pos = -1;
                else begin
                    win = (window == 16'd0) ? 1 : int'(window);
                    cnt = 0; cnts = 0; pos = 1;
                end
            end else if (pos <= win) begin
                if (!en) pos = -1;
                else begin
                    if (edge_seen) begin
                        if (cnt < 65535) cnt++;
                        if (cnts < 15) cnts++;
                    end
                    pos++;
                end
            end else begin
                if (m_v && !yumi) ovr = 1'b1;
                mm = cnt; mms = cnts; v = 1'b1;
`ifdef BSG_CLK_MON_METER_LOCK_EN
                dev = (cnt > int'(target)) ? cnt - int'(target) : int'(target) - cnt;
                if (dev <= int'(tol)) begin
                    if (lcnt < 4) lcnt++;
                    lck = (lcnt == 4);
                end else begin
                    lcnt = 0; lck = 1'b0;
                end
`endif
                pos = en ? 0 : -1;
            end
            if (pos < 0) begin lcnt = 0; lck = 1'b0; end
            m_pos <= pos; m_win <= win; m_cnt <= cnt; m_cnt_s <= cnts;
            m_meas <= mm; m_meas_s <= mms; m_v <= v; m_ovr <= ovr; m_lcnt <= lcnt; m_lock <= lck;
            p3 <= p2; p2 <= p1; p1 <= div_clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("meas", 32'(meas), 32'(m_meas));
            check("meas_v", 32'(meas_v), 32'(m_v));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("sat_meas", 32'(meas_s), 32'(m_meas_s));
            check("sat_meas_v", 32'(meas_v_s), 32'(m_v));
`ifdef BSG_CLK_MON_METER_LOCK_EN
            check("lock", 32'(lock), 32'(m_lock));
`endif
        end
    end

    // Input driver: div_per 0 gives random div_clk; yumi_mode 0 never, 1 always, 2 random, 3 only in result cycle.
    int div_per = 10;
    int ph = 0;
    int yumi_mode = 1;

    always @(negedge clk) begin
        if (div_per == 0) div_clk = 1'($urandom_range(0, 1));
        else begin
            div_clk = (ph < div_per / 2);
            ph = (ph + 1) % div_per;
        end
        case (yumi_mode)
            0: yumi = 1'b0;
            1: yumi = m_v;
            2: yumi = m_v & 1'($urandom_range(0, 1));
            default: yumi = m_v && (m_pos >= 2) && (m_pos == m_win + 1);
        endcase
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rise(input string name, input int bound, output int waited);
        logic prev;
        bit   ok;
        prev = meas_v; waited = 0; ok = 0;
        while (waited < bound) begin
            @(negedge clk);
            waited++;
            if (meas_v && !prev) begin ok = 1; break; end
            prev = meas_v;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: meas_v rise not seen, waited %0d, required within %0d", name, waited, bound);
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0; en = 1'b0; window = 16'd100; div_per = 10; yumi_mode = 1;
        cycles(3);
        check("rst_meas", 32'(meas), 32'd0);
        check("rst_meas_v", 32'(meas_v), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;

        // Basic: idle, arm, 100 count cycles, result cycle -> visible 103 edges after enable.
        en = 1'b1;
        wait_rise("basic_first", 300, w);
        check("basic_latency", 32'(w), 32'd103);
        check("basic_range", 32'(meas >= 16'd9 && meas <= 16'd11), 32'd1);
        wait_rise("basic_second", 300, w);
        check("basic_period", 32'(w), 32'd102);
        en = 1'b0; cycles(5);

        // Saturation: 200 cycles of period 4 gives ~50 edges, pinned at 15 in the 4-bit instance.
        window = 16'd200; div_per = 4; en = 1'b1;
        wait_rise("sat", 400, w);
        check("sat_value", 32'(meas_s), 32'd15);
        check("sat_wide_range", 32'(meas >= 16'd49 && meas <= 16'd51), 32'd1);
        en = 1'b0; cycles(5);

        // Overrun: two results without consumption.
        yumi_mode = 0; window = 16'd10; div_per = 6; en = 1'b1;
        wait_rise("ovr_first", 50, w);
        cycles(30);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(meas_v), 32'd1);

        // Reset mid-count: asynchronous clear, then restart from idle.
        yumi_mode = 1; window = 16'd100; div_per = 10;
        cycles(30);
        #2 rst_n = 1'b0;
        #1;
        check("arst_meas", 32'(meas), 32'd0);
        check("arst_meas_v", 32'(meas_v), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        wait_rise("arst_restart", 300, w);
        check("arst_latency", 32'(w), 32'd103);
        en = 1'b0; cycles(3);

        // Consumption in the result cycle keeps valid up and flags no overrun.
        yumi_mode = 3; window = 16'd8; div_per = 0; en = 1'b1;
        cycles(60);
        check("yumi_done_ovr", 32'(overrun), 32'd0);
        check("yumi_done_v", 32'(meas_v), 32'd1);
        en = 1'b0; cycles(3);

        // Abort mid-count leaves the held result untouched.
        yumi_mode = 0; window = 16'd50; div_per = 7; en = 1'b1;
        cycles(20);
        en = 1'b0; cycles(6);

        // Zero window acts as one: result every 3 cycles.
        yumi_mode = 1; window = 16'd0; div_per = 0; en = 1'b1;
        cycles(4);
        wait_rise("zero_a", 20, w);
        wait_rise("zero_b", 20, w);
        check("zero_period", 32'(w), 32'd3);
        en = 1'b0; cycles(3);

        // Random phase.
        for (int i = 0; i < 40; i++) begin
            window = 16'($urandom_range(0, 20));
            en = ($urandom_range(0, 3) != 0);
            yumi_mode = $urandom_range(0, 2);
            div_per = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(4, 12);
            cycles($urandom_range(1, 40));
        end
        en = 1'b0; cycles(3);

`ifdef BSG_CLK_MON_METER_LOCK_EN
        // Period 10 over 100 cycles gives exactly 10 edges; lock after the 4th result.
        yumi_mode = 1; window = 16'd100; div_per = 10; en = 1'b1;
        for (int k = 0; k < 3; k++) wait_rise("lock_pre", 300, w);
        check("lock_after3", 32'(lock), 32'd0);
        wait_rise("lock_4th", 300, w);
        check("lock_after4", 32'(lock), 32'd1);
        div_per = 5;
        wait_rise("lock_5th", 300, w);
        check("lock_lost", 32'(lock), 32'd0);
        en = 1'b0; cycles(3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
